// File: rtl/kgd_pkg.sv
// Shared constants and types for the KGD scanout engine: 800x600 raster timing,
// KGD image geometry and the depth of the scanout pipeline.
package kgd_pkg;

    localparam int H_VISIBLE = 800;
    localparam int H_FRONT   = 40;
    localparam int H_SYNC    = 128;
    localparam int H_BACK    = 88;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 600;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 4;
    localparam int V_BACK    = 23;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int IMG_W    = 400;
    localparam int IMG_H    = 286;
    localparam int V_OFFSET = 14;

    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b1;

    localparam int ADDR_W   = 17;
    localparam int CNT_W    = 11;
    localparam int SCAN_LAT = 3;

    typedef logic [ADDR_W-1:0] vram_addr_t;
    typedef logic [CNT_W-1:0]  raster_cnt_t;

    // Raster-position flags that travel alongside the pixel fetch.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic in_image;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_CLEAR = '{hsync: 1'b0, vsync: 1'b0, active: 1'b0, in_image: 1'b0};

    function automatic logic in_span(input raster_cnt_t cnt, input int lo, input int len);
        return (cnt >= raster_cnt_t'(lo)) && (cnt < raster_cnt_t'(lo + len));
    endfunction

endpackage

// File: rtl/kgd_scanout_vga_timing.sv
// Raster timing generator: pixel/line counters and the raw (active-high,
// polarity-free) sync and active-area decode at stage 0.
module vga_timing
    import kgd_pkg::*;
#(
    parameter int H_ACT = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_ACT = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic        clock,
    input  logic        reset,
    output raster_cnt_t hc,
    output raster_cnt_t vc,
    output logic        hs_win,
    output logic        vs_win,
    output logic        active,
    output logic        origin
);

    localparam raster_cnt_t H_LAST   = raster_cnt_t'(H_ACT + H_FP + H_SW + H_BP - 1);
    localparam raster_cnt_t V_LAST   = raster_cnt_t'(V_ACT + V_FP + V_SW + V_BP - 1);
    localparam raster_cnt_t CNT_ZERO = {CNT_W{1'b0}};
    localparam raster_cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    raster_cnt_t hc_r;
    raster_cnt_t vc_r;

    // Pixel and line counters; the line counter steps when the pixel counter wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            hc_r <= CNT_ZERO;
            vc_r <= CNT_ZERO;
        end else if (hc_r == H_LAST) begin
            hc_r <= CNT_ZERO;
            if (vc_r == V_LAST) begin
                vc_r <= CNT_ZERO;
            end else begin
                vc_r <= vc_r + CNT_ONE;
            end
        end else begin
            hc_r <= hc_r + CNT_ONE;
        end
    end

    // Stage-0 decode straight off the counter registers.
    always_comb begin
        hs_win = in_span(hc_r, H_ACT + H_FP, H_SW);
        vs_win = in_span(vc_r, V_ACT + V_FP, V_SW);
        active = (hc_r < raster_cnt_t'(H_ACT)) && (vc_r < raster_cnt_t'(V_ACT));
        origin = (hc_r == CNT_ZERO) && (vc_r == CNT_ZERO);
    end

    assign hc = hc_r;
    assign vc = vc_r;

endmodule

// File: rtl/kgd_scanout.sv
// KGD scanout engine: walks the 1-bit video RAM with 2x pixel/line doubling,
// centres the image vertically and emits aligned pixel, sync and enable.
module kgd_scanout
    import kgd_pkg::*;
#(
    parameter int   H_ACT    = H_VISIBLE,
    parameter int   H_FP     = H_FRONT,
    parameter int   H_SW     = H_SYNC,
    parameter int   H_BP     = H_BACK,
    parameter int   V_ACT    = V_VISIBLE,
    parameter int   V_FP     = V_FRONT,
    parameter int   V_SW     = V_SYNC,
    parameter int   V_BP     = V_BACK,
    parameter int   IMG_COLS = IMG_W,
    parameter int   IMG_ROWS = IMG_H,
    parameter int   ROW_OFS  = V_OFFSET,
    parameter logic HS_LVL   = HS_POL,
    parameter logic VS_LVL   = VS_POL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              kgd_en,
    input  logic              vram_q,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              pix,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_sof
);

    localparam raster_cnt_t X_END     = raster_cnt_t'(2 * IMG_COLS);
    localparam raster_cnt_t X_LAST    = raster_cnt_t'(2 * IMG_COLS - 1);
    localparam vram_addr_t  ROW_STEP  = vram_addr_t'(IMG_COLS);
    localparam vram_addr_t  ADDR_ZERO = {ADDR_W{1'b0}};
    localparam vram_addr_t  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    raster_cnt_t hc_s;
    raster_cnt_t vc_s;
    logic        hs_win_s;
    logic        vs_win_s;
    logic        active_s;
    logic        origin_s;
    logic        in_image_s;
    scan_flags_t flags_s;

    vram_addr_t  line_base_r;
    vram_addr_t  x_img_r;
    vram_addr_t  vram_addr_r;
    logic        row_odd_r;
    logic        en_frame_r;
    scan_flags_t flag_pipe_r [SCAN_LAT-1];
    logic        pix_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        de_r;

    vga_timing #(
        .H_ACT (H_ACT),
        .H_FP  (H_FP),
        .H_SW  (H_SW),
        .H_BP  (H_BP),
        .V_ACT (V_ACT),
        .V_FP  (V_FP),
        .V_SW  (V_SW),
        .V_BP  (V_BP)
    ) u_timing (
        .clock  (clock),
        .reset  (reset),
        .hc     (hc_s),
        .vc     (vc_s),
        .hs_win (hs_win_s),
        .vs_win (vs_win_s),
        .active (active_s),
        .origin (origin_s)
    );

    // Image window and the flag bundle that rides along with the fetch.
    always_comb begin
        in_image_s = active_s && in_span(vc_s, ROW_OFS, 2 * IMG_ROWS) && (hc_s < X_END);
        flags_s    = '{hsync: hs_win_s, vsync: vs_win_s, active: active_s, in_image: in_image_s};
    end

    // Incremental address walk: x_img steps every second pixel, line_base steps by
    // one image row after each odd image line, so no multiplier is needed.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_base_r <= ADDR_ZERO;
            x_img_r     <= ADDR_ZERO;
            row_odd_r   <= 1'b0;
            vram_addr_r <= ADDR_ZERO;
        end else begin
            if (origin_s) begin
                line_base_r <= ADDR_ZERO;
                row_odd_r   <= 1'b0;
            end else if (in_image_s && (hc_s == X_LAST)) begin
                row_odd_r <= ~row_odd_r;
                if (row_odd_r) begin
                    line_base_r <= line_base_r + ROW_STEP;
                end
            end
            if (!in_image_s) begin
                x_img_r <= ADDR_ZERO;
            end else if (hc_s[0]) begin
                x_img_r <= x_img_r + ADDR_ONE;
            end
            vram_addr_r <= in_image_s ? (line_base_r + x_img_r) : ADDR_ZERO;
        end
    end

    // Enable is only sampled on the frame origin so a frame is never torn.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_frame_r <= 1'b0;
        end else if (origin_s) begin
            en_frame_r <= kgd_en;
        end
    end

    // Flag delay (stages 1-2) matching the RAM read, then the stage-3 output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SCAN_LAT - 1; i++) begin
                flag_pipe_r[i] <= FLAGS_CLEAR;
            end
            pix_r   <= 1'b0;
            hsync_r <= ~HS_LVL;
            vsync_r <= ~VS_LVL;
            de_r    <= 1'b0;
        end else begin
            flag_pipe_r[0] <= flags_s;
            for (int i = 1; i < SCAN_LAT - 1; i++) begin
                flag_pipe_r[i] <= flag_pipe_r[i-1];
            end
            pix_r   <= vram_q & flag_pipe_r[SCAN_LAT-2].in_image & en_frame_r;
            hsync_r <= flag_pipe_r[SCAN_LAT-2].hsync ? HS_LVL : ~HS_LVL;
            vsync_r <= flag_pipe_r[SCAN_LAT-2].vsync ? VS_LVL : ~VS_LVL;
            de_r    <= flag_pipe_r[SCAN_LAT-2].active;
        end
    end

    assign vram_addr = vram_addr_r;
    assign pix       = pix_r;
    assign hsync     = hsync_r;
    assign vsync     = vsync_r;
    assign de        = de_r;
    assign frame_sof = origin_s & ~reset;

endmodule

// File: tb/tb_kgd_scanout.sv
// Bench for kgd_scanout: full-size raster for the first lines, plus a shrunken
// raster (inverted hsync, narrow image) to reach frame-level behaviour quickly.
module tb_kgd_scanout;

    typedef struct packed {
        int h_vis; int h_fp; int h_sw; int h_bp;
        int v_vis; int v_fp; int v_sw; int v_bp;
        int img_w; int img_h; int v_ofs;
        bit hs_pol; bit vs_pol;
    } cfg_t;

    localparam cfg_t CFG_A = '{h_vis: 800, h_fp: 40, h_sw: 128, h_bp: 88,
                               v_vis: 600, v_fp: 1, v_sw: 4, v_bp: 23,
                               img_w: 400, img_h: 286, v_ofs: 14, hs_pol: 1'b1, vs_pol: 1'b1};
    localparam cfg_t CFG_B = '{h_vis: 16, h_fp: 3, h_sw: 5, h_bp: 4,
                               v_vis: 12, v_fp: 1, v_sw: 2, v_bp: 3,
                               img_w: 6, img_h: 4, v_ofs: 2, hs_pol: 1'b0, vs_pol: 1'b1};
    localparam int K14 = 14 * 1056;
    localparam int K15 = 15 * 1056;
    localparam int K16 = 16 * 1056;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a, rst_b, kgd_en_a, kgd_en_b, vram_q_a, vram_q_b;
    logic [16:0] vram_addr_a, vram_addr_b;
    logic pix_a, hsync_a, vsync_a, de_a, frame_sof_a;
    logic pix_b, hsync_b, vsync_b, de_b, frame_sof_b;

    int total = 0;
    int bad = 0;

    kgd_scanout u_dut_a (
        .clock(clock), .reset(rst_a), .kgd_en(kgd_en_a), .vram_q(vram_q_a),
        .vram_addr(vram_addr_a), .pix(pix_a), .hsync(hsync_a), .vsync(vsync_a),
        .de(de_a), .frame_sof(frame_sof_a)
    );

    kgd_scanout #(
        .H_ACT(16), .H_FP(3), .H_SW(5), .H_BP(4),
        .V_ACT(12), .V_FP(1), .V_SW(2), .V_BP(3),
        .IMG_COLS(6), .IMG_ROWS(4), .ROW_OFS(2), .HS_LVL(1'b0), .VS_LVL(1'b1)
    ) u_dut_b (
        .clock(clock), .reset(rst_b), .kgd_en(kgd_en_b), .vram_q(vram_q_b),
        .vram_addr(vram_addr_b), .pix(pix_b), .hsync(hsync_b), .vsync(vsync_b),
        .de(de_b), .frame_sof(frame_sof_b)
    );

    // Video RAM stand-in: registered read returning the address LSB.
    always @(posedge clock) begin
        vram_q_a <= vram_addr_a[0];
        vram_q_b <= vram_addr_b[0];
    end

    function automatic int line_len(input cfg_t c);
        return c.h_vis + c.h_fp + c.h_sw + c.h_bp;
    endfunction

    function automatic int frame_len(input cfg_t c);
        return line_len(c) * (c.v_vis + c.v_fp + c.v_sw + c.v_bp);
    endfunction

    function automatic bit pos_active(input cfg_t c, input int q);
        return ((q % line_len(c)) < c.h_vis) && ((q / line_len(c)) < c.v_vis);
    endfunction

    function automatic bit pos_image(input cfg_t c, input int q);
        int hc = q % line_len(c);
        int vc = q / line_len(c);
        return pos_active(c, q) && (vc >= c.v_ofs) && (vc < c.v_ofs + 2 * c.img_h) && (hc < 2 * c.img_w);
    endfunction

    function automatic int pos_addr(input cfg_t c, input int q);
        int hc = q % line_len(c);
        int vc = q / line_len(c);
        return pos_image(c, q) ? ((vc - c.v_ofs) / 2) * c.img_w + hc / 2 : 0;
    endfunction

    function automatic bit pos_hs(input cfg_t c, input int q);
        int hc = q % line_len(c);
        return (hc >= c.h_vis + c.h_fp) && (hc < c.h_vis + c.h_fp + c.h_sw);
    endfunction

    function automatic bit pos_vs(input cfg_t c, input int q);
        int vc = q / line_len(c);
        return (vc >= c.v_vis + c.v_fp) && (vc < c.v_vis + c.v_fp + c.v_sw);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per instance: raster position, cycles since reset, latched enable.
    int t_m [2];
    int age_m [2];
    bit en_m [2];
    bit valid_m [2];
    wire [1:0] rst_v = {rst_b, rst_a};
    wire [1:0] en_v  = {kgd_en_b, kgd_en_a};

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_v[i]) begin
                t_m[i]     <= 0;
                age_m[i]   <= 0;
                en_m[i]    <= 1'b0;
                valid_m[i] <= 1'b1;
            end else begin
                if (t_m[i] == 0) en_m[i] <= en_v[i];
                t_m[i] <= (t_m[i] + 1) % frame_len(i == 0 ? CFG_A : CFG_B);
                if (age_m[i] < 8) age_m[i] <= age_m[i] + 1;
            end
        end
    end

    task automatic check_inst(input int i, input cfg_t c, input string tag, input logic [16:0] a,
                              input logic p, input logic hs, input logic vs, input logic d,
                              input logic sof, input logic r);
        int fl = frame_len(c);
        int pos = t_m[i];
        int q = (pos + fl - 3) % fl;
        int exp_addr = (age_m[i] >= 1) ? pos_addr(c, (pos + fl - 1) % fl) : 0;
        bit ready = (age_m[i] >= 3);
        bit exp_de = ready && pos_active(c, q);
        bit exp_pix = ready && pos_image(c, q) && en_m[i] && (pos_addr(c, q) % 2 == 1);
        bit exp_hs = (ready && pos_hs(c, q)) ? c.hs_pol : !c.hs_pol;
        bit exp_vs = (ready && pos_vs(c, q)) ? c.vs_pol : !c.vs_pol;
        chk({tag, "_sof"}, int'(sof), int'((pos == 0) && !r));
        chk({tag, "_addr"}, int'(a), exp_addr);
        chk({tag, "_de"}, int'(d), int'(exp_de));
        chk({tag, "_pix"}, int'(p), int'(exp_pix));
        chk({tag, "_hsync"}, int'(hs), int'(exp_hs));
        chk({tag, "_vsync"}, int'(vs), int'(exp_vs));
    endtask

    // Single cycle-by-cycle compare of both instances against the model.
    always @(negedge clock) begin
        if (valid_m[0]) check_inst(0, CFG_A, "a", vram_addr_a, pix_a, hsync_a, vsync_a, de_a, frame_sof_a, rst_a);
        if (valid_m[1]) check_inst(1, CFG_B, "b", vram_addr_b, pix_b, hsync_b, vsync_b, de_b, frame_sof_b, rst_b);
    end

    task automatic seq_a();
        int de_cnt, hs_cnt, hs_first;
        de_cnt = 0; hs_cnt = 0; hs_first = -1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("a_rst_hsync", int'(hsync_a), 0);
        chk("a_rst_vsync", int'(vsync_a), 0);
        chk("a_rst_de", int'(de_a), 0);
        chk("a_rst_pix", int'(pix_a), 0);
        chk("a_rst_addr", int'(vram_addr_a), 0);
        chk("a_rst_sof", int'(frame_sof_a), 0);
        @(posedge clock); #1;
        rst_a = 1'b0;
        for (int k = 0; k < K16 + 802; k++) begin
            @(negedge clock);
            if (k == 0) chk("a_sof_first", int'(frame_sof_a), 1);
            if (k < 1059) begin
                de_cnt += int'(de_a);
                hs_cnt += int'(hsync_a);
                if (hsync_a && hs_first < 0) hs_first = k;
            end
            if (k == 1059) begin
                chk("a_de_width", de_cnt, 800);
                chk("a_hs_width", hs_cnt, 128);
                chk("a_hs_start", hs_first, 843);
            end
            case (k)
                K14 + 1:   chk("a_row0_addr_x0", int'(vram_addr_a), 0);
                K14 + 3:   begin chk("a_row0_addr_x1", int'(vram_addr_a), 1); chk("a_row0_pix0", int'(pix_a), 0); end
                K14 + 5:   chk("a_row0_pix2", int'(pix_a), 1);
                K14 + 6:   chk("a_row0_pix3", int'(pix_a), 1);
                K14 + 7:   chk("a_row0_pix4", int'(pix_a), 0);
                K14 + 800: chk("a_row0_addr_end", int'(vram_addr_a), 399);
                K15 + 3:   chk("a_row0_repeat", int'(vram_addr_a), 1);
                K16 + 1:   chk("a_row1_addr_start", int'(vram_addr_a), 400);
                K16 + 800: chk("a_row1_addr_end", int'(vram_addr_a), 799);
                default: ;
            endcase
            @(posedge clock); #1;
        end
    endtask

    task automatic seq_b();
        int ones, n;
        bit seen;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("b_rst_hsync", int'(hsync_b), 1);
        chk("b_rst_vsync", int'(vsync_b), 0);
        @(posedge clock); #1;
        rst_b = 1'b0;
        ones = 0;
        for (int k = 0; k < 504; k++) begin
            if (k == 224) kgd_en_b = 1'b1;
            @(negedge clock);
            if (k == 0) chk("b_sof_first", int'(frame_sof_b), 1);
            ones += int'(pix_b);
            @(posedge clock); #1;
        end
        chk("b_frame0_pix_ones", ones, 0);
        ones = 0;
        for (int k = 504; k < 1008; k++) begin
            @(negedge clock);
            if (k == 504) chk("b_sof_frame1", int'(frame_sof_b), 1);
            ones += int'(pix_b);
            @(posedge clock); #1;
        end
        chk("b_frame1_pix_ones", ones, 48);
        for (int k = 1008; k < 1155; k++) begin
            @(negedge clock);
            @(posedge clock); #1;
        end
        rst_b = 1'b1;
        @(posedge clock); #1;
        rst_b = 1'b0;
        @(negedge clock);
        chk("b_post_rst_sof", int'(frame_sof_b), 1);
        chk("b_post_rst_de", int'(de_b), 0);
        chk("b_post_rst_pix", int'(pix_b), 0);
        chk("b_post_rst_addr", int'(vram_addr_b), 0);
        chk("b_post_rst_hsync", int'(hsync_b), 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 600) begin
            @(posedge clock); #1;
            @(negedge clock);
            n++;
            if (frame_sof_b) seen = 1'b1;
        end
        chk("b_sof_period", n, 504);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        kgd_en_a = 1'b1;
        kgd_en_b = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
